// File: rtl/data_mux.sv
// data_mux: N-way word selector with range flag, hold-able registered copy and optional sticky error (DATA_MUX_STICKY_ERR_EN)
module data_mux #(
  parameter int N_OPTIONS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH = (N_OPTIONS > 1) ? $clog2(N_OPTIONS) : 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [SEL_WIDTH-1:0]  i_sel,
  input  logic [DATA_WIDTH-1:0] i_val [0:N_OPTIONS-1],
  input  logic                  i_en,
  output logic [DATA_WIDTH-1:0] o_val,
  output logic [DATA_WIDTH-1:0] o_val_q,
  output logic                  o_sel_invalid,
  output logic                  o_sel_err
);
  // Compare against each legal index so an out-of-range select yields zero, never a wrapped word.
  always_comb begin
    o_val = '0;
    for (int i = 0; i < N_OPTIONS; i++) o_val = (int'(i_sel) == i) ? i_val[i] : o_val;
  end
  assign o_sel_invalid = int'(i_sel) >= N_OPTIONS;
  always_ff @(posedge i_clk)
    if (!i_rst_n) o_val_q <= RESET_VALUE;
    else if (i_en) o_val_q <= o_val;
`ifdef DATA_MUX_STICKY_ERR_EN
  always_ff @(posedge i_clk)
    if (!i_rst_n) o_sel_err <= 1'b0;
    else if (o_sel_invalid) o_sel_err <= 1'b1;
`else
  assign o_sel_err = 1'b0;
`endif
endmodule

// File: tb/tb_data_mux.sv
// tb_data_mux: directed and random checks of data_mux at N=4, N=3 and N=1 against a behavioural model
module tb_data_mux;
`ifdef DATA_MUX_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  localparam logic [31:0] RV4 = 32'hdead_beef;
  localparam logic [31:0] RV3 = 32'h0000_0055;
  logic clk = 1'b0;
  logic rst_n, en;
  logic [1:0] sel4, sel3;
  logic [0:0] sel1;
  logic [31:0] val4 [0:3];
  logic [31:0] val3 [0:2];
  logic [31:0] val1 [0:0];
  logic [31:0] o4, q4, o3, q3, o1, q1;
  logic inv4, err4, inv3, err3, inv1, err1;
  logic [31:0] m_q4, m_q3, m_q1;
  logic m_err3, m_err1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mux #(.N_OPTIONS(4), .DATA_WIDTH(32), .RESET_VALUE(RV4)) u4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel4), .i_val(val4), .i_en(en),
    .o_val(o4), .o_val_q(q4), .o_sel_invalid(inv4), .o_sel_err(err4));
  data_mux #(.N_OPTIONS(3), .DATA_WIDTH(32), .RESET_VALUE(RV3)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel3), .i_val(val3), .i_en(en),
    .o_val(o3), .o_val_q(q3), .o_sel_invalid(inv3), .o_sel_err(err3));
  data_mux #(.N_OPTIONS(1), .DATA_WIDTH(32)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel1), .i_val(val1), .i_en(en),
    .o_val(o1), .o_val_q(q1), .o_sel_invalid(inv1), .o_sel_err(err1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: check combinational outputs, advance the model over the edge, check registered outputs.
  task automatic step();
    int s4, s3, s1;
    logic [31:0] e4, e3, e1;
    #1;
    s4 = int'(sel4); s3 = int'(sel3); s1 = int'(sel1);
    e4 = (s4 < 4) ? val4[s4] : 32'h0;
    e3 = (s3 < 3) ? val3[s3] : 32'h0;
    e1 = (s1 < 1) ? val1[s1] : 32'h0;
    chk("o_val4", o4, e4);
    chk("inv4", 32'(inv4), 32'(s4 >= 4));
    chk("o_val3", o3, e3);
    chk("inv3", 32'(inv3), 32'(s3 >= 3));
    chk("o_val1", o1, e1);
    chk("inv1", 32'(inv1), 32'(s1 >= 1));
    @(posedge clk);
    if (!rst_n) begin
      m_q4 = RV4; m_q3 = RV3; m_q1 = 32'h0; m_err3 = 1'b0; m_err1 = 1'b0;
    end else begin
      if (en) begin m_q4 = e4; m_q3 = e3; m_q1 = e1; end
      if (STICKY && s3 >= 3) m_err3 = 1'b1;
      if (STICKY && s1 >= 1) m_err1 = 1'b1;
    end
    #1;
    chk("q4", q4, m_q4);
    chk("q3", q3, m_q3);
    chk("q1", q1, m_q1);
    chk("err4", 32'(err4), 32'h0);
    chk("err3", 32'(err3), 32'(m_err3));
    chk("err1", 32'(err1), 32'(m_err1));
  endtask

  task automatic randomize_vals();
    for (int i = 0; i < 4; i++) val4[i] = $urandom;
    for (int i = 0; i < 3; i++) val3[i] = $urandom;
    val1[0] = $urandom;
  endtask

  initial begin
    randomize_vals();
    sel4 = 2'd0; sel3 = 2'd0; sel1 = 1'b0;
    rst_n = 1'b0; en = 1'b1;
    step();
    val4[0] = 32'h0000_0104; val4[1] = 32'h0000_2000; val4[2] = 32'h8000_0000; val4[3] = 32'h0000_1234;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel4 = 2'(i);
      step();
    end
    rst_n = 1'b0; en = 1'b1; sel4 = 2'd1;
    step();
    rst_n = 1'b1; sel4 = 2'd2;
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomize_vals();
      sel4 = 2'($urandom_range(0, 3)); sel3 = 2'($urandom_range(0, 2));
      step();
    end
    en = 1'b1;
    step();
    sel3 = 2'd3;
    step();
    sel3 = 2'd0;
    step();
    step();
    sel1 = 1'b1;
    step();
    sel1 = 1'b0;
    step();
    rst_n = 1'b0; en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int n = 0; n < 300; n++) begin
      randomize_vals();
      sel4 = 2'($urandom_range(0, 3));
      sel3 = 2'($urandom_range(0, 3));
      sel1 = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 15) != 0);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
